iex_mc: RTL and testbench

Parametrised execute stage with multi-cycle multiply/divide. It sits between the decode/operand-fetch stage and the memory stage and keeps the existing Control-word bit layout. It adds:
- configurable datapath width;
- signed and unsigned iterative multiply/divide that stalls the pipeline through `Busy`;
- arithmetic right shift;
- defined divide-by-zero results;
- a valid/stall handshake.

Single-cycle ops register their result on the next edge. Mult/div occupy the stage for W+1 cycles.

---
 rtl/iex_mc_pkg.sv | 35 +++
 rtl/iex_mc_iter_muldiv.sv | 108 ++++++++++
 rtl/iex_mc.sv | 137 +++++++++++++
 tb/tb_iex_mc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iex_mc_pkg.sv
// Shared definitions for the iex_mc execute stage: control-word bit positions
// and the multiply/divide sequencer state encoding.
package ex_pkg;

    localparam int CTL_UNSIGNED = 0;
    localparam int CTL_ADD      = 1;
    localparam int CTL_SUB      = 2;
    localparam int CTL_MULT     = 3;
    localparam int CTL_DIV      = 4;
    localparam int CTL_AND      = 5;
    localparam int CTL_OR       = 6;
    localparam int CTL_NOR      = 7;
    localparam int CTL_XOR      = 8;
    localparam int CTL_SLL      = 9;
    localparam int CTL_SRL      = 10;
    localparam int CTL_ARITH    = 11;
    localparam int CTL_MEMREAD  = 13;
    localparam int CTL_MEMWRITE = 14;
    localparam int CTL_BRANCH   = 15;
    localparam int CTL_CMPEQ    = 16;
    localparam int CTL_INVERT   = 17;
    localparam int CTL_JUMP     = 18;
    localparam int CTL_TESTNEG  = 19;
    localparam int CTL_TESTPOS  = 20;
    localparam int CTL_TESTZ    = 21;
    localparam int CTL_TESTNZ   = 22;
    localparam int CTL_WB       = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } ex_state_t;

endpackage

// File: rtl/iex_mc_iter_muldiv.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes, with a
// final sign fix. Occupies W cycles in RUN plus one cycle in FIX.
module iter_muldiv
    import ex_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    input  logic         is_div,
    input  logic         is_unsigned,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    ex_state_t     state;
    logic [CW-1:0] count;
    logic [W-1:0]  acc;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          neg_res;
    logic          div_mode;
    logic          div_zero;

    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W:0]    rem_sh;
    logic [W+1:0]  diff;
    logic [W-1:0]  rem_next;
    logic [W-1:0]  quot_next;
    logic [W-1:0]  raw;

    assign a_neg = !is_unsigned && op_a[W-1];
    assign b_neg = !is_unsigned && op_b[W-1];
    assign a_mag = a_neg ? (~op_a + W'(1)) : op_a;
    assign b_mag = b_neg ? (~op_b + W'(1)) : op_b;

    // Divide: acc holds the partial remainder, opa shifts the dividend out
    // and the quotient bits in; opb is the divisor.
    always_comb begin
        rem_sh    = {acc, opa[W-1]};
        diff      = {1'b0, rem_sh} - {2'b00, opb};
        rem_next  = rem_sh[W-1:0];
        quot_next = {opa[W-2:0], 1'b0};
        if (!diff[W+1]) begin
            rem_next     = diff[W-1:0];
            quot_next[0] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            neg_res  <= 1'b0;
            div_mode <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa      <= a_mag;
                        opb      <= b_mag;
                        acc      <= '0;
                        count    <= '0;
                        neg_res  <= a_neg ^ b_neg;
                        div_mode <= is_div;
                        div_zero <= is_div && (op_b == '0);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (div_mode) begin
                        acc <= rem_next;
                        opa <= quot_next;
                    end else begin
                        if (opb[0]) acc <= acc + opa;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end
                    count <= count + CW'(1);
                    if (count == LAST_STEP) state <= FIX;
                end
                FIX:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
    assign raw    = div_mode ? opa : acc;
    assign result = (neg_res && !div_zero) ? (~raw + W'(1)) : raw;
    assign busy   = (state != IDLE);
    assign done   = (state == FIX);

endmodule

// File: rtl/iex_mc.sv
// Execute stage: single-cycle ALU, branch resolution and output registers,
// with multiply/divide delegated to the iterative iter_muldiv unit.
module iex_mc
    import ex_pkg::*;
#(
    parameter int W   = 32,
    parameter int SAW = $clog2(W)
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           InValid,
    input  logic [W-1:0]   Op1,
    input  logic [W-1:0]   Op2,
    input  logic [W-1:0]   Op3,
    input  logic [SAW-1:0] SA,
    input  logic [4:0]     DstIn,
    input  logic [31:0]    Control,
    input  logic [W-1:0]   NextPCIn,
    output logic           Busy,
    output logic           OutValid,
    output logic [W-1:0]   Result,
    output logic [W-1:0]   ExStoreValOut,
    output logic [4:0]     DstOut,
    output logic           WriteBack,
    output logic           isMemRead,
    output logic           isMemWrite,
    output logic           BranchTaken,
    output logic [W-1:0]   BranchTarget
);

    logic         accept;
    logic         is_muldiv;
    logic         md_start;
    logic         md_done;
    logic [W-1:0] md_result;
    logic [W-1:0] sext_imm;
    logic [W-1:0] alu_res;
    logic         cond;
    logic [4:0]   lat_dst;
    logic         lat_wb;
    logic [W-1:0] lat_store;
    logic         unused_ctl;

    assign accept    = InValid && !Busy;
    assign is_muldiv = Control[CTL_MULT] || Control[CTL_DIV];
    assign md_start  = accept && is_muldiv;
    assign sext_imm  = {{(W-16){Op2[15]}}, Op2[15:0]};
    assign unused_ctl = ^{Control[30:23], Control[12]};

    iter_muldiv #(.W(W)) u_muldiv (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (md_start),
        .is_div      (Control[CTL_DIV]),
        .is_unsigned (Control[CTL_UNSIGNED]),
        .op_a        (Op1),
        .op_b        (Op2),
        .busy        (Busy),
        .done        (md_done),
        .result      (md_result)
    );

    // Every enabled unit contributes; decode normally enables exactly one.
    always_comb begin
        alu_res = '0;
        if (Control[CTL_ADD]) alu_res |= Op1 + Op2;
        if (Control[CTL_SUB]) alu_res |= Op1 - Op2;
        if (Control[CTL_AND]) alu_res |= Op1 & Op2;
        if (Control[CTL_OR])  alu_res |= Op1 | Op2;
        if (Control[CTL_NOR]) alu_res |= ~(Op1 | Op2);
        if (Control[CTL_XOR]) alu_res |= Op1 ^ Op2;
        if (Control[CTL_SLL]) alu_res |= Op1 << SA;
        if (Control[CTL_SRL]) begin
            if (Control[CTL_ARITH]) alu_res |= W'($signed(Op1) >>> SA);
            else                    alu_res |= Op1 >> SA;
        end
        if (Control[CTL_MEMREAD] || Control[CTL_MEMWRITE]) alu_res |= Op1 + sext_imm;
    end

    always_comb begin
        cond = (Control[CTL_CMPEQ]   && (Op1 == Op3))
            || (Control[CTL_TESTNEG] &&  Op1[W-1])
            || (Control[CTL_TESTPOS] && !Op1[W-1])
            || (Control[CTL_TESTZ]   && (Op1 == '0))
            || (Control[CTL_TESTNZ]  && (Op1 != '0));
    end

    assign BranchTaken  = accept && (Control[CTL_JUMP] ||
                          (Control[CTL_BRANCH] && (Control[CTL_INVERT] ^ cond)));
    assign BranchTarget = Control[CTL_JUMP] ? Op2 : (NextPCIn + (sext_imm << 2));

    // Writeback attributes of a mult/div are held until its FIX cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lat_dst   <= '0;
            lat_wb    <= 1'b0;
            lat_store <= '0;
        end else if (md_start) begin
            lat_dst   <= DstIn;
            lat_wb    <= Control[CTL_WB];
            lat_store <= Op3;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            OutValid      <= 1'b0;
            Result        <= '0;
            ExStoreValOut <= '0;
            DstOut        <= '0;
            WriteBack     <= 1'b0;
            isMemRead     <= 1'b0;
            isMemWrite    <= 1'b0;
        end else begin
            OutValid   <= 1'b0;
            WriteBack  <= 1'b0;
            isMemRead  <= 1'b0;
            isMemWrite <= 1'b0;
            if (md_done) begin
                OutValid      <= 1'b1;
                Result        <= md_result;
                DstOut        <= lat_dst;
                WriteBack     <= lat_wb;
                ExStoreValOut <= lat_store;
            end else if (accept && !is_muldiv) begin
                OutValid      <= 1'b1;
                Result        <= alu_res;
                DstOut        <= DstIn;
                WriteBack     <= Control[CTL_WB];
                isMemRead     <= Control[CTL_MEMREAD];
                isMemWrite    <= Control[CTL_MEMWRITE];
                ExStoreValOut <= Op3;
            end
        end
    end

endmodule

// File: tb/tb_iex_mc.sv
// Randomized scoreboard bench for iex_mc (W=32) with directed corner cases.
module tb_iex_mc;

    localparam int W = 32;

    localparam int B_UNS = 0,  B_ADD = 1,  B_SUB = 2,  B_MUL = 3,  B_DIV = 4;
    localparam int B_AND = 5,  B_OR = 6,   B_NOR = 7,  B_XOR = 8,  B_SLL = 9;
    localparam int B_SRL = 10, B_ARI = 11, B_MRD = 13, B_MWR = 14, B_BR = 15;
    localparam int B_CEQ = 16, B_INV = 17, B_JMP = 18, B_TNG = 19, B_TPS = 20;
    localparam int B_TZ = 21,  B_TNZ = 22, B_WB = 31;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid;
    logic [31:0] Op1, Op2, Op3, NextPCIn, Control;
    logic [4:0]  SA, DstIn;
    logic        Busy, OutValid, WriteBack, isMemRead, isMemWrite, BranchTaken;
    logic [31:0] Result, ExStoreValOut, BranchTarget;
    logic [4:0]  DstOut;

    typedef struct {
        logic [31:0] res;
        logic [31:0] store;
        logic [4:0]  dst;
        logic        wb;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t expQ[$];
    int   nCompared = 0;
    int   nMismatched = 0;

    iex_mc #(.W(W)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .InValid       (InValid),
        .Op1           (Op1),
        .Op2           (Op2),
        .Op3           (Op3),
        .SA            (SA),
        .DstIn         (DstIn),
        .Control       (Control),
        .NextPCIn      (NextPCIn),
        .Busy          (Busy),
        .OutValid      (OutValid),
        .Result        (Result),
        .ExStoreValOut (ExStoreValOut),
        .DstOut        (DstOut),
        .WriteBack     (WriteBack),
        .isMemRead     (isMemRead),
        .isMemWrite    (isMemWrite),
        .BranchTaken   (BranchTaken),
        .BranchTarget  (BranchTarget)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bitOf(input int i);
        return 32'd1 << i;
    endfunction

    function automatic logic [31:0] sext16(input logic [31:0] v);
        int off;
        off = $signed(v[15:0]);
        return 32'(off);
    endfunction

    // Reference result straight from the instruction semantics.
    function automatic logic [31:0] modelResult(input logic [31:0] ctl, input logic [31:0] a,
                                                input logic [31:0] b, input logic [4:0] sa);
        logic [31:0] r;
        int ia, ib;
        if (ctl[B_MUL]) return a * b;
        if (ctl[B_DIV]) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (ctl[B_UNS]) return a / b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            ia = a;
            ib = b;
            return 32'(ia / ib);
        end
        r = 32'd0;
        if (ctl[B_ADD]) r |= a + b;
        if (ctl[B_SUB]) r |= a - b;
        if (ctl[B_AND]) r |= a & b;
        if (ctl[B_OR])  r |= a | b;
        if (ctl[B_NOR]) r |= ~(a | b);
        if (ctl[B_XOR]) r |= a ^ b;
        if (ctl[B_SLL]) r |= a << sa;
        if (ctl[B_SRL]) begin
            if (ctl[B_ARI] && a[31]) r |= (a >> sa) | ~(32'hFFFF_FFFF >> sa);
            else                     r |= a >> sa;
        end
        if (ctl[B_MRD] || ctl[B_MWR]) r |= a + sext16(b);
        return r;
    endfunction

    function automatic logic modelTaken(input logic [31:0] ctl, input logic [31:0] a, input logic [31:0] c);
        logic hit;
        hit = (ctl[B_CEQ] && a == c) || (ctl[B_TNG] && a[31]) || (ctl[B_TPS] && !a[31])
           || (ctl[B_TZ] && a == 0) || (ctl[B_TNZ] && a != 0);
        return ctl[B_JMP] || (ctl[B_BR] && (ctl[B_INV] ^ hit));
    endfunction

    function automatic logic [31:0] modelTarget(input logic [31:0] ctl, input logic [31:0] b, input logic [31:0] npc);
        if (ctl[B_JMP]) return b;
        return npc + sext16(b) * 4;
    endfunction

    task automatic applyStimulus(input logic [31:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [4:0] sa, input logic [4:0] dst,
                                 input logic [31:0] npc);
        exp_t e;
        int   busyCycles;
        bit   fell;
        Control  = ctl;
        Op1      = a;
        Op2      = b;
        Op3      = c;
        SA       = sa;
        DstIn    = dst;
        NextPCIn = npc;
        InValid  = 1'b1;
        #1;
        checkOutput("busy_before_issue", 32'(Busy), 32'd0);
        checkOutput("branch_taken", 32'(BranchTaken), 32'(modelTaken(ctl, a, c)));
        checkOutput("branch_target", BranchTarget, modelTarget(ctl, b, npc));
        e.res   = modelResult(ctl, a, b, sa);
        e.store = c;
        e.dst   = dst;
        e.wb    = ctl[B_WB];
        e.mr    = !(ctl[B_MUL] || ctl[B_DIV]) && ctl[B_MRD];
        e.mw    = !(ctl[B_MUL] || ctl[B_DIV]) && ctl[B_MWR];
        expQ.push_back(e);
        @(posedge Clk);
        if (ctl[B_MUL] || ctl[B_DIV]) begin
            busyCycles = 0;
            fell = 1'b0;
            for (int k = 0; k < 100 && !fell; k++) begin
                @(negedge Clk);
                if (Busy) busyCycles++;
                else      fell = 1'b1;
            end
            checkOutput("busy_cycles", 32'(busyCycles), 32'(W + 1));
        end else begin
            @(negedge Clk);
            checkOutput("busy_single", 32'(Busy), 32'd0);
        end
        InValid = 1'b0;
    endtask

    // Scoreboard monitor: every OutValid pulse must match the oldest expectation.
    always @(negedge Clk) begin
        if (!Reset && OutValid) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_outvalid", 32'(OutValid), 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("result", Result, e.res);
                checkOutput("store_val", ExStoreValOut, e.store);
                checkOutput("dst", 32'(DstOut), 32'(e.dst));
                checkOutput("writeback", 32'(WriteBack), 32'(e.wb));
                checkOutput("memread", 32'(isMemRead), 32'(e.mr));
                checkOutput("memwrite", 32'(isMemWrite), 32'(e.mw));
            end
        end
    end

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ctl, a, b;
        Reset    = 1'b1;
        InValid  = 1'b1;
        Control  = $urandom;
        Op1      = $urandom;
        Op2      = $urandom;
        Op3      = $urandom;
        SA       = 5'($urandom);
        DstIn    = 5'($urandom);
        NextPCIn = $urandom;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_outvalid", 32'(OutValid), 32'd0);
        checkOutput("rst_result", Result, 32'd0);
        checkOutput("rst_store", ExStoreValOut, 32'd0);
        checkOutput("rst_dst", 32'(DstOut), 32'd0);
        checkOutput("rst_wb", 32'(WriteBack), 32'd0);
        checkOutput("rst_mr", 32'(isMemRead), 32'd0);
        checkOutput("rst_mw", 32'(isMemWrite), 32'd0);
        Reset   = 1'b0;
        InValid = 1'b0;
        @(negedge Clk);

        applyStimulus(bitOf(B_ADD) | bitOf(B_WB), 32'd5, 32'd7, 32'd0, 5'd0, 5'd3, 32'h40);
        applyStimulus(bitOf(B_MUL) | bitOf(B_WB), 32'hFFFF_FFFD, 32'd7, 32'h55, 5'd0, 5'd4, 32'h44);
        applyStimulus(bitOf(B_DIV) | bitOf(B_UNS) | bitOf(B_WB), 32'd10, 32'd0, 32'd0, 5'd0, 5'd5, 32'h48);
        applyStimulus(bitOf(B_DIV) | bitOf(B_WB), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd6, 32'h4C);
        applyStimulus(bitOf(B_DIV) | bitOf(B_WB), 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd0, 5'd7, 32'h50);
        applyStimulus(bitOf(B_DIV) | bitOf(B_WB), 32'hFFFF_FFF6, 32'd0, 32'd0, 5'd0, 5'd8, 32'h54);

        // Abort a signed divide ten steps into RUN.
        Control = bitOf(B_DIV) | bitOf(B_WB);
        Op1     = 32'd100;
        Op2     = 32'd3;
        InValid = 1'b1;
        @(posedge Clk);
        repeat (10) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        InValid = 1'b0;
        checkOutput("busy_after_abort", 32'(Busy), 32'd0);
        checkOutput("outvalid_after_abort", 32'(OutValid), 32'd0);
        repeat (W + 4) @(negedge Clk);
        applyStimulus(bitOf(B_ADD) | bitOf(B_WB), 32'd1, 32'd1, 32'd0, 5'd0, 5'd9, 32'h58);

        applyStimulus(bitOf(B_SRL) | bitOf(B_ARI) | bitOf(B_WB), 32'h8000_0000, 32'h8000_0000,
                      32'd0, 5'd4, 5'd10, 32'h5C);
        applyStimulus(bitOf(B_BR) | bitOf(B_CEQ), 32'h1234, 32'h0000_FFFF, 32'h1234, 5'd0, 5'd0, 32'h100);

        for (int i = 0; i < 48; i++) begin
            int r;
            r = $urandom_range(0, 11);
            case (r)
                0:  ctl = bitOf(B_ADD);
                1:  ctl = bitOf(B_SUB);
                2:  ctl = bitOf(B_AND);
                3:  ctl = bitOf(B_OR);
                4:  ctl = bitOf(B_NOR);
                5:  ctl = bitOf(B_XOR);
                6:  ctl = bitOf(B_SLL);
                7:  ctl = bitOf(B_SRL);
                8:  ctl = bitOf(B_SRL) | bitOf(B_ARI);
                9:  ctl = $urandom_range(0, 1) ? bitOf(B_MRD) : bitOf(B_MWR);
                10: ctl = bitOf(B_MUL);
                default: ctl = bitOf(B_DIV);
            endcase
            if ($urandom_range(0, 1) == 1) ctl |= bitOf(B_WB);
            if ($urandom_range(0, 1) == 1) ctl |= bitOf(B_UNS);
            if ($urandom_range(0, 2) == 0) ctl |= ($urandom & 32'hFF) << 15;
            a = pickOperand();
            b = pickOperand();
            applyStimulus(ctl, a, b, $urandom_range(0, 1) ? a : $urandom, 5'($urandom),
                          5'($urandom), $urandom);
        end

        repeat (5) @(negedge Clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
